// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// funct3 op codes, FSM state encoding and per-op signedness predicates.
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit for RISC-V M-extension ops.
// Works on operand magnitudes for WIDTH steps, then applies signs in a FIX cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result
);

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 a_neg_q, a_neg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH:0]       bmag_q, bmag_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept_s;
  logic                 a_neg_s, b_neg_s;
  logic [WIDTH:0]       a_ext_s, b_ext_s, amag_s, bmag_s;
  logic                 div_zero_s, ovf_s;
  logic [WIDTH-1:0]     spec_res_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH+1:0]     div_diff_s;
  logic                 div_ok_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quot_fix_s, rem_fix_s, fix_res_s;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = out_valid_q && !flush;
  assign result    = result_q;

  // Operand decode at accept: signs, W+1-bit magnitudes and special cases
  always_comb begin
    accept_s   = in_valid && in_ready && !flush;
    a_neg_s    = a_signed(op) & a[WIDTH-1];
    b_neg_s    = b_signed(op) & b[WIDTH-1];
    a_ext_s    = {a_neg_s, a};
    b_ext_s    = {b_neg_s, b};
    amag_s     = a_neg_s ? (~a_ext_s + {{WIDTH{1'b0}}, 1'b1}) : a_ext_s;
    bmag_s     = b_neg_s ? (~b_ext_s + {{WIDTH{1'b0}}, 1'b1}) : b_ext_s;
    div_zero_s = is_div(op) && (b == {WIDTH{1'b0}});
    ovf_s      = ((op == OP_DIV) || (op == OP_REM)) &&
                 (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    if (div_zero_s) begin
      spec_res_s = op[1] ? a : {WIDTH{1'b1}};
    end else begin
      spec_res_s = op[1] ? {WIDTH{1'b0}} : a;
    end
  end

  // One radix-2 iteration for each datapath, plus the sign fix-up
  always_comb begin
    mul_sum_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + bmag_q;
    mul_next_s  = prod_q[0] ? {mul_sum_s, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};
    div_shift_s = {rem_q[WIDTH-1:0], prod_q[WIDTH-1]};
    div_diff_s  = {1'b0, div_shift_s} - {1'b0, bmag_q};
    // A set top bit means the shifted remainder already exceeds any divisor.
    div_ok_s    = rem_q[WIDTH] | ~div_diff_s[WIDTH+1];
    prod_fix_s  = neg_q ? (~prod_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_q;
    quot_fix_s  = neg_q ? (~prod_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : prod_q[WIDTH-1:0];
    rem_fix_s   = a_neg_q ? (~rem_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_q[WIDTH-1:0];
    case (op_q)
      OP_MUL:                       fix_res_s = prod_fix_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_res_s = quot_fix_s;
      OP_REM, OP_REMU:              fix_res_s = rem_fix_s;
      default:                      fix_res_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM next state and datapath register updates
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    a_neg_d     = a_neg_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    rem_d       = rem_q;
    bmag_d      = bmag_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d    = op;
          neg_d   = a_neg_s ^ b_neg_s;
          a_neg_d = a_neg_s;
          cnt_d   = {CNT_W{1'b0}};
          prod_d  = {{(WIDTH-1){1'b0}}, amag_s};
          rem_d   = {(WIDTH+1){1'b0}};
          bmag_d  = bmag_s;
          if (div_zero_s || ovf_s) begin
            state_d     = DONE;
            result_d    = spec_res_s;
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (is_div(op_q)) begin
          prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], div_ok_s};
          rem_d  = div_ok_s ? div_diff_s[WIDTH:0] : div_shift_s;
        end else begin
          prod_d = mul_next_s;
        end
        state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : CALC;
      end
      FIX: begin
        state_d     = DONE;
        result_d    = fix_res_s;
        out_valid_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
    end else begin
      out_valid_d = out_valid_d;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      neg_q       <= 1'b0;
      a_neg_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      prod_q      <= {(2*WIDTH){1'b0}};
      rem_q       <= {(WIDTH+1){1'b0}};
      bmag_q      <= {(WIDTH+1){1'b0}};
      result_q    <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      a_neg_q     <= a_neg_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      rem_q       <= rem_d;
      bmag_q      <= bmag_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit (WIDTH=32) with hand-written
// sequences for flush, reset-mid-op and held in_valid.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_res = '0;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int         lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp, input int exp_lat,
                        input bit hold);
    int lat;
    bit busy_ok;
    bit seen;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    op = o; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    lat = 1; busy_ok = 1'b1; seen = 1'b0;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) busy_ok = 1'b0;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({name, " out_valid seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({name, " result"}, 64'(result), 64'(exp));
      chk({name, " latency"}, 64'(lat), 64'(exp_lat));
      chk({name, " in_ready low while busy"}, 64'(busy_ok), 64'd1);
      @(negedge clk);
      chk({name, " out_valid one cycle"}, 64'(out_valid), 64'd0);
      chk({name, " in_ready after done"}, 64'(in_ready), 64'd1);
    end
    last_res = exp;
  endtask

  initial begin
    int ov;
    vecs[0]  = '{"MUL 7*-3",          3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{"MULH min*min",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{"MULHU max*max",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[3]  = '{"MULHSU -1*max",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{"DIV -7/2",          3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vecs[5]  = '{"REM -7/2",          3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[6]  = '{"DIVU 100/7",        3'd5, 32'd100,       32'd7,         32'd14,        34};
    vecs[7]  = '{"REMU 100/7",        3'd7, 32'd100,       32'd7,         32'd2,         34};
    vecs[8]  = '{"DIVU 5/0",          3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{"REM 5/0",           3'd6, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{"DIV ovf",           3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{"REM ovf",           3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{"MUL shift",         3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34};
    vecs[13] = '{"MULH -1*-1",        3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[14] = '{"DIV 7/-2",          3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vecs[15] = '{"REM 7/-2",          3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[16] = '{"DIV -7/-2",         3'd4, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 34};
    vecs[17] = '{"REMU min/max",      3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
    vecs[18] = '{"DIV 0/0",           3'd4, 32'd0,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[19] = '{"REMU 5/0",          3'd7, 32'd5,         32'd0,         32'd5,         1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);
    end

    // Flush 10 cycles into a DIV
    op = 3'd4; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    ov = 0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush in_ready next cycle", 64'(in_ready), 64'd1);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush result unchanged", 64'(result), 64'(last_res));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("flush no out_valid", 64'(ov), 64'd0);
    run_op("MUL 6*7 after flush", 3'd0, 32'd6, 32'd7, 32'd42, 34, 1'b0);

    // Held in_valid during busy must not start a second op
    run_op("MUL 3*5 held valid", 3'd0, 32'd3, 32'd5, 32'd15, 34, 1'b1);
    ov = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("held valid no second result", 64'(ov), 64'd0);

    // Reset mid-MUL with in_valid held high
    op = 3'd0; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    ov = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready || out_valid) ov++;
    end
    chk("busy with held valid", 64'(ov), 64'd0);
    reset = 1'b1;
    #1;
    chk("in_ready low in reset", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("reset mid-op in_ready", 64'(in_ready), 64'd0);
    chk("reset mid-op result", 64'(result), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready after reset release", 64'(in_ready), 64'd1);
    ov = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("no out_valid after reset mid-op", 64'(ov), 64'd0);
    chk("result still 0 after reset", 64'(result), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised, multi-cycle integer multiply/divide unit for the EX stage; implements the RISC-V M-extension ops that the single-cycle ALU cannot.
- Sits beside the ALU; the EX stage routes M-ops here and stalls the pipeline while the unit is not ready.
- Iterative radix-2 core: one shift-add or shift-subtract step per cycle on operand magnitudes, then a sign-fix cycle.

Parameters:
- WIDTH, 32, operand/result width in bits (XLEN); any value >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of the in-flight op (branch mispredict/trap).
- in_valid  in  1  op request.
- in_ready  out  1  unit can accept; high only in IDLE and not in reset.
- op  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  WIDTH  rs1 operand.
- b  in  WIDTH  rs2 operand.
- out_valid  out  1  one-cycle pulse; result is valid.
- result  out  WIDTH  registered result; held until the next op is accepted.

Behaviour:
- Reset: state IDLE, out_valid 0, result 0, counter 0, all datapath registers 0. Reset mid-op abandons the op; no out_valid.
- Accept: in_valid && in_ready at an edge latches op, the sign flags (signed-ness per op: a signed for MULH/MULHSU/DIV/REM, b signed for MULH/DIV/REM) and the operand magnitudes.
- States: IDLE -> CALC (normal accept) | DONE (special-case accept). CALC -> FIX after WIDTH steps. FIX -> DONE. DONE -> IDLE unconditionally.
- Multiply: 2*WIDTH product register; each CALC step conditionally adds |b| into the upper half, then shifts right. FIX negates the product if the sign flags differ. MUL returns low WIDTH bits; MULH/MULHSU/MULHU return high WIDTH bits.
- Divide: restoring; remainder register WIDTH+1 bits; each step shifts in the next dividend bit, trial-subtracts |b|, keeps the result if non-negative, and shifts the quotient bit in. FIX: quotient negated if the sign flags differ; remainder takes the sign of a.
- Latency, normal ops: out_valid high for exactly one cycle, WIDTH+2 edges after the accepting edge (34 for WIDTH=32). in_ready returns high in the cycle after out_valid.
- Special cases, resolved at accept and going straight to DONE (out_valid 1 edge after accept):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed overflow (DIV/REM with a = most-negative, b = -1): DIV -> a; REM -> 0.
- No back-pressure on the output; the consumer must capture result on the out_valid cycle.
- Flush:
  - Any state other than IDLE: next state IDLE, out_valid suppressed (including in DONE, where it is forced 0 combinationally), result unchanged.
  - In IDLE: flush blocks acceptance that cycle, even with in_valid high.
- in_valid while busy is ignored; the op is not queued.
- Arithmetic: magnitude of the most-negative value is computed in WIDTH+1 bits so it is not lost; all intermediate sums are sized to avoid carry loss.

Decomposition:
- Package mdu_pkg holds the funct3 op constants (OP_MUL .. OP_REMU), the state encoding (IDLE, CALC, FIX, DONE) and the helper predicates is_div(op) and a_signed/b_signed(op).
- Single module plus the package; an optional combinational sub-module mdu_step (one add/sub-shift iteration) is permitted but not required.

Test Plan (WIDTH=32):
- MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; out_valid exactly 34 edges after accept, one cycle wide; in_ready low throughout.
- MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each with out_valid 1 edge after accept.
- flush asserted 10 cycles into a DIV -> no out_valid, in_ready high the next cycle; a following MUL 6*7 -> 42 with normal latency.
- reset asserted mid-MUL -> out_valid never rises, result 0, in_ready low during reset and high the cycle after deassertion; in_valid held high during busy is not double-accepted.
